// File: rtl/fwd_scoreboard.sv
// Operand-forwarding scoreboard: tracks in-flight register writers past ID,
// selects forward sources for each ID operand and raises a stall on unready loads.
module fwd_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int NSRC       = 2,
    parameter int DATAW      = 32,
    parameter int REGW       = 5,
    parameter int LOAD_READY = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    advance,
    input  logic                    issue_valid,
    input  logic                    issue_wen,
    input  logic                    issue_load,
    input  logic [REGW-1:0]         issue_dest,
    input  logic [NSRC-1:0]         src_valid,
    input  logic [NSRC*REGW-1:0]    src_reg,
    input  logic [DEPTH-1:0]        kill,
    input  logic                    kill_issue,
    input  logic [DEPTH*DATAW-1:0]  stage_data,
    output logic                    stall_req,
    output logic [NSRC*4-1:0]       fwd_sel,
    output logic [NSRC*DATAW-1:0]   fwd_data,
    output logic [15:0]             stall_count
);

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_load;
    logic [DEPTH-1:0] ent_ready;
    logic [REGW-1:0]  ent_dest [DEPTH];

    logic [NSRC-1:0]  src_stall;
    logic [REGW-1:0]  m_src;
    logic             m_hit;
    logic             m_rdy;
    logic [3:0]       m_sel;
    logic [DATAW-1:0] m_data;
    logic             new_valid;

    always_comb begin
        ent_ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_ready[i] = ent_valid[i] & (~ent_load[i] | (i >= LOAD_READY));
        end
    end

    // Scan oldest to youngest so the lowest-index match is the one that sticks.
    always_comb begin
        src_stall = '0;
        fwd_sel   = '0;
        fwd_data  = '0;
        m_src     = '0;
        m_hit     = 1'b0;
        m_rdy     = 1'b0;
        m_sel     = '0;
        m_data    = '0;
        for (int s = 0; s < NSRC; s++) begin
            m_src  = src_reg[s*REGW +: REGW];
            m_hit  = 1'b0;
            m_rdy  = 1'b0;
            m_sel  = '0;
            m_data = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (ent_valid[i] && (ent_dest[i] == m_src)) begin
                    m_hit  = 1'b1;
                    m_rdy  = ent_ready[i];
                    m_sel  = 4'(i + 1);
                    m_data = stage_data[i*DATAW +: DATAW];
                end
            end
            if (src_valid[s] && (m_src != '0) && m_hit) begin
                if (m_rdy) begin
                    fwd_sel[s*4 +: 4]         = m_sel;
                    fwd_data[s*DATAW +: DATAW] = m_data;
                end else begin
                    src_stall[s] = 1'b1;
                end
            end
        end
    end

    assign stall_req = (|src_stall) & issue_valid & ~kill_issue;
    assign new_valid = issue_valid & issue_wen & (issue_dest != '0) & ~kill_issue & ~stall_req;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ent_valid   <= '0;
            ent_load    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_dest[i] <= '0;
            end
            stall_count <= '0;
        end else if (advance) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                ent_valid[i] <= ent_valid[i-1] & ~kill[i-1];
                ent_load[i]  <= ent_load[i-1];
                ent_dest[i]  <= ent_dest[i-1];
            end
            ent_valid[0] <= new_valid;
            ent_load[0]  <= issue_load;
            ent_dest[0]  <= issue_dest;
            if (stall_req && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end else begin
            // Frozen pipeline: squashes still land, nothing moves.
            ent_valid <= ent_valid & ~kill;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: cycle-by-cycle vector table on the default
// configuration plus hand sequences for mid-stream reset and counter saturation.
module tb_fwd_scoreboard;

    logic         CLK;
    logic         RST;
    logic         advance;
    logic         issue_valid;
    logic         issue_wen;
    logic         issue_load;
    logic [4:0]   issue_dest;
    logic [1:0]   src_valid;
    logic [9:0]   src_reg;
    logic [2:0]   kill;
    logic         kill_issue;
    logic [95:0]  stage_data;
    logic         stall_req;
    logic [7:0]   fwd_sel;
    logic [63:0]  fwd_data;
    logic [15:0]  stall_count;

    logic         s_adv;
    logic         s_iv;
    logic         s_wen;
    logic         s_ld;
    logic [4:0]   s_dest;
    logic [0:0]   s_sv;
    logic [4:0]   s_src;
    logic [7:0]   s_kill;
    logic         s_ki;
    logic [255:0] s_sd;
    logic         s_stall;
    logic [3:0]   s_sel;
    logic [31:0]  s_data;
    logic [15:0]  s_cnt;

    int checks = 0;
    int errors = 0;
    int cur_row = 0;

    logic [31:0] sd [3];

    fwd_scoreboard dut (
        .CLK(CLK), .RST(RST), .advance(advance), .issue_valid(issue_valid),
        .issue_wen(issue_wen), .issue_load(issue_load), .issue_dest(issue_dest),
        .src_valid(src_valid), .src_reg(src_reg), .kill(kill), .kill_issue(kill_issue),
        .stage_data(stage_data), .stall_req(stall_req), .fwd_sel(fwd_sel),
        .fwd_data(fwd_data), .stall_count(stall_count)
    );

    fwd_scoreboard #(.DEPTH(8), .NSRC(1), .DATAW(32), .REGW(5), .LOAD_READY(7)) u_sat (
        .CLK(CLK), .RST(RST), .advance(s_adv), .issue_valid(s_iv),
        .issue_wen(s_wen), .issue_load(s_ld), .issue_dest(s_dest),
        .src_valid(s_sv), .src_reg(s_src), .kill(s_kill), .kill_issue(s_ki),
        .stage_data(s_sd), .stall_req(s_stall), .fwd_sel(s_sel),
        .fwd_data(s_data), .stall_count(s_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       adv, iv, wen, ld;
        logic [4:0] dest;
        logic [1:0] sv;
        logic [4:0] s0, s1;
        logic [2:0] kl;
        logic       ki;
        logic       e_stall;
        logic [3:0] e_sel0, e_sel1;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic adv, input logic iv, input logic wen, input logic ld,
                       input logic [4:0] dest, input logic [1:0] sv, input logic [4:0] s0,
                       input logic [4:0] s1, input logic [2:0] kl, input logic ki,
                       input logic e_stall, input logic [3:0] e_sel0, input logic [3:0] e_sel1,
                       input logic [15:0] e_cnt);
        vec_t v;
        v.adv = adv; v.iv = iv; v.wen = wen; v.ld = ld; v.dest = dest; v.sv = sv;
        v.s0 = s0; v.s1 = s1; v.kl = kl; v.ki = ki; v.e_stall = e_stall;
        v.e_sel0 = e_sel0; v.e_sel1 = e_sel1; v.e_cnt = e_cnt;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, cur_row, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [3:0] sel);
        return (sel == 4'd0) ? 32'd0 : sd[sel - 4'd1];
    endfunction

    task automatic check_outputs(input logic e_stall, input logic [3:0] e0, input logic [3:0] e1,
                                 input logic [15:0] e_cnt);
        chk("stall_req", 64'(stall_req), 64'(e_stall));
        chk("fwd_sel0", 64'(fwd_sel[3:0]), 64'(e0));
        chk("fwd_sel1", 64'(fwd_sel[7:4]), 64'(e1));
        chk("fwd_data0", 64'(fwd_data[31:0]), 64'(exp_data(e0)));
        chk("fwd_data1", 64'(fwd_data[63:32]), 64'(exp_data(e1)));
        chk("stall_count", 64'(stall_count), 64'(e_cnt));
    endtask

    task automatic idle_main();
        advance = 1'b1; issue_valid = 1'b0; issue_wen = 1'b0; issue_load = 1'b0;
        issue_dest = 5'd0; src_valid = 2'b00; src_reg = 10'd0; kill = 3'b000;
        kill_issue = 1'b0;
    endtask

    initial begin
        sd[0] = 32'h1111_1111;
        sd[1] = 32'h2222_2222;
        sd[2] = 32'h3333_3333;
        stage_data = {sd[2], sd[1], sd[0]};
        for (int i = 0; i < 8; i++) s_sd[i*32 +: 32] = 32'h5000_0000 + 32'(i);
        s_adv = 1'b0; s_iv = 1'b0; s_wen = 1'b0; s_ld = 1'b0; s_dest = 5'd0;
        s_sv = 1'b0; s_src = 5'd0; s_kill = 8'd0; s_ki = 1'b0;
        idle_main();

        //  adv iv wen ld dest sv  s0  s1  kill  ki  stall sel0 sel1 cnt
        add(1, 0, 0, 0, 0,  0, 0,  0,  0,    0,  0, 0, 0, 0);   // 0  idle after reset
        add(1, 1, 1, 0, 3,  0, 0,  0,  0,    0,  0, 0, 0, 0);   // 1  add r3
        add(1, 1, 0, 0, 0,  1, 3,  0,  0,    0,  0, 1, 0, 0);   // 2  r3 in EX
        add(1, 1, 0, 0, 0,  1, 3,  0,  0,    0,  0, 2, 0, 0);   // 3  r3 one stage on
        add(1, 1, 1, 1, 8,  0, 0,  0,  0,    0,  0, 0, 0, 0);   // 4  load r8
        add(1, 1, 0, 0, 0,  2, 0,  8,  0,    0,  1, 0, 0, 0);   // 5  load-use stall
        add(1, 1, 0, 0, 0,  2, 0,  8,  0,    0,  0, 0, 2, 1);   // 6  load now forwardable
        add(1, 1, 1, 0, 5,  0, 0,  0,  0,    0,  0, 0, 0, 1);   // 7  r5
        add(1, 1, 1, 0, 9,  0, 0,  0,  0,    0,  0, 0, 0, 1);   // 8  r9
        add(1, 1, 1, 0, 5,  0, 0,  0,  0,    0,  0, 0, 0, 1);   // 9  r5 again
        add(1, 1, 1, 0, 0,  1, 5,  0,  0,    0,  0, 1, 0, 1);   // 10 youngest r5, write r0
        add(1, 1, 0, 0, 0,  3, 0,  5,  0,    0,  0, 0, 2, 1);   // 11 r0 never forwards
        add(1, 1, 1, 0, 7,  0, 0,  0,  0,    0,  0, 0, 0, 1);   // 12 r7
        add(1, 0, 0, 0, 0,  1, 7,  0,  0,    0,  0, 1, 0, 1);   // 13
        add(0, 1, 0, 0, 0,  1, 7,  0,  0,    0,  0, 2, 0, 1);   // 14 freeze
        add(0, 1, 0, 0, 0,  1, 7,  0,  0,    0,  0, 2, 0, 1);   // 15
        add(0, 1, 0, 0, 0,  1, 7,  0,  0,    0,  0, 2, 0, 1);   // 16
        add(0, 1, 0, 0, 0,  1, 7,  0,  0,    0,  0, 2, 0, 1);   // 17
        add(0, 1, 0, 0, 0,  1, 7,  0,  3'b010, 0, 0, 2, 0, 1);  // 18 kill in freeze
        add(0, 1, 0, 0, 0,  1, 7,  0,  0,    0,  0, 0, 0, 1);   // 19 killed
        add(1, 1, 1, 1, 10, 0, 0,  0,  0,    0,  0, 0, 0, 1);   // 20 load r10
        add(0, 1, 0, 0, 0,  1, 10, 0,  0,    0,  1, 0, 0, 1);   // 21 stall while frozen
        add(0, 1, 0, 0, 0,  1, 10, 0,  0,    0,  1, 0, 0, 1);   // 22
        add(1, 1, 0, 0, 0,  1, 10, 0,  0,    0,  1, 0, 0, 1);   // 23 counted stall
        add(1, 0, 0, 0, 0,  1, 10, 0,  0,    0,  0, 2, 0, 2);   // 24
        add(1, 1, 1, 1, 11, 0, 0,  0,  0,    0,  0, 0, 0, 2);   // 25 load r11
        add(1, 1, 1, 0, 12, 1, 11, 0,  0,    1,  0, 0, 0, 2);   // 26 kill_issue masks stall
        add(1, 1, 0, 0, 0,  3, 12, 11, 0,    0,  0, 0, 2, 2);   // 27 r12 never entered
        add(1, 1, 1, 0, 6,  0, 0,  0,  0,    0,  0, 0, 0, 2);   // 28 r6
        add(1, 1, 1, 0, 4,  0, 0,  0,  0,    0,  0, 0, 0, 2);   // 29 r4
        add(1, 1, 1, 0, 2,  0, 0,  0,  0,    0,  0, 0, 0, 2);   // 30 r2
        add(1, 0, 0, 0, 0,  3, 2,  4,  3'b011, 0, 0, 1, 2, 2);  // 31 kill still matches now
        add(1, 0, 0, 0, 0,  3, 2,  4,  0,    0,  0, 0, 0, 2);   // 32
        add(1, 0, 0, 0, 0,  1, 6,  0,  0,    0,  0, 0, 0, 2);   // 33 r6 retired

        // Reset with an operand looking for a register nobody holds.
        RST = 1'b1;
        src_valid = 2'b11; src_reg = {5'd3, 5'd8}; issue_valid = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        cur_row = -1;
        check_outputs(1'b0, 4'd0, 4'd0, 16'd0);
        RST = 1'b0;

        for (int r = 0; r < vq.size(); r++) begin
            @(negedge CLK);
            cur_row = r;
            advance = vq[r].adv; issue_valid = vq[r].iv; issue_wen = vq[r].wen;
            issue_load = vq[r].ld; issue_dest = vq[r].dest; src_valid = vq[r].sv;
            src_reg = {vq[r].s1, vq[r].s0}; kill = vq[r].kl; kill_issue = vq[r].ki;
            #1;
            check_outputs(vq[r].e_stall, vq[r].e_sel0, vq[r].e_sel1, vq[r].e_cnt);
        end

        // Mid-stream reset landing on a counted stall edge.
        cur_row = 100;
        @(negedge CLK);
        idle_main();
        issue_valid = 1'b1; issue_wen = 1'b1; issue_load = 1'b1; issue_dest = 5'd8;
        @(negedge CLK);
        issue_wen = 1'b0; issue_load = 1'b0; issue_dest = 5'd0;
        src_valid = 2'b01; src_reg = {5'd0, 5'd8};
        RST = 1'b1;
        #1;
        chk("pre_reset_stall", 64'(stall_req), 64'd1);
        @(negedge CLK);
        #1;
        cur_row = 101;
        check_outputs(1'b0, 4'd0, 4'd0, 16'd0);
        RST = 1'b0;
        idle_main();
        advance = 1'b0;

        // Saturation on the deep instance: a load every 8 cycles, 7 of 8 stalled.
        cur_row = 200;
        s_adv = 1'b1; s_iv = 1'b1; s_wen = 1'b1; s_ld = 1'b1; s_dest = 5'd8;
        s_sv = 1'b1; s_src = 5'd8;
        repeat (800) @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("sat_count_800", 64'(s_cnt), 64'd700);
        chk("sat_stall_800", 64'(s_stall), 64'd0);
        chk("sat_sel_800", 64'(s_sel), 64'd8);
        chk("sat_data_800", 64'(s_data), 64'h5000_0007);
        repeat (74200) @(posedge CLK);
        @(negedge CLK);
        #1;
        cur_row = 201;
        chk("sat_count_max", 64'(s_cnt), 64'hFFFF);
        RST = 1'b1;
        @(negedge CLK);
        #1;
        cur_row = 202;
        chk("sat_rst_count", 64'(s_cnt), 64'd0);
        chk("sat_rst_stall", 64'(s_stall), 64'd0);
        chk("sat_rst_sel", 64'(s_sel), 64'd0);
        chk("sat_rst_data", 64'(s_data), 64'd0);
        RST = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
